// File: rtl/dcache_mem_req_queue_if.sv
// Request and memory-side bundles for the D-cache memory request queue.
// dcache_mem_req_if : MSHR mux -> queue (master = MSHR side, slave = queue).
// dcache_mem_bus_if : queue -> external memory port (master = queue, slave = memory).

interface dcache_mem_req_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int LINE_WIDTH    = 128,
  parameter int SERIAL_WIDTH  = 4,
  parameter int WSERIAL_WIDTH = 4
);
  logic                     req_valid;
  logic                     req_we;
  logic [ADDR_WIDTH-1:0]    req_addr;
  logic [LINE_WIDTH-1:0]    req_data;
  logic                     req_ack;
  logic [SERIAL_WIDTH-1:0]  req_serial;
  logic [WSERIAL_WIDTH-1:0] req_wserial;

  modport master (output req_valid, req_we, req_addr, req_data,
                  input  req_ack, req_serial, req_wserial);
  modport slave  (input  req_valid, req_we, req_addr, req_data,
                  output req_ack, req_serial, req_wserial);
endinterface

interface dcache_mem_bus_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int LINE_WIDTH    = 128,
  parameter int MSERIAL_WIDTH = 4
);
  logic                     mem_valid;
  logic                     mem_we;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [LINE_WIDTH-1:0]    mem_data;
  logic [MSERIAL_WIDTH-1:0] mem_serial;
  logic                     mem_ready;
  logic                     mem_rsp_valid;

  modport master (output mem_valid, mem_we, mem_addr, mem_data, mem_serial,
                  input  mem_ready, mem_rsp_valid);
  modport slave  (input  mem_valid, mem_we, mem_addr, mem_data, mem_serial,
                  output mem_ready, mem_rsp_valid);
endinterface

// File: rtl/dcache_mem_req_queue.sv
// D-cache memory request queue: in-order FIFO of line refills/write-backs
// between the MSHR request mux and the memory port. Assigns read/write
// serials on acceptance and throttles reads against MAX_OUTSTANDING.
// rst_i is asynchronous, active low.
// Optional: define DCACHE_MEM_REQ_BYPASS_EN to let a request arriving at an
// empty queue go to memory in the same cycle.

module dcache_mem_req_queue #(
  parameter int DEPTH           = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int LINE_WIDTH      = 128,
  parameter int SERIAL_WIDTH    = 4,
  parameter int WSERIAL_WIDTH   = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  dcache_mem_req_if.slave                    req,
  dcache_mem_bus_if.master                   mem,
  output logic [$clog2(DEPTH):0]             occupancy_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_underflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int MS_W  = (SERIAL_WIDTH > WSERIAL_WIDTH) ? SERIAL_WIDTH : WSERIAL_WIDTH;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0] data;
    logic [MS_W-1:0]       serial;
  } entry_t;

  entry_t                   ram_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]         occ_q, occ_d;
  logic [OUT_W-1:0]         out_q, out_d;
  logic [SERIAL_WIDTH-1:0]  rser_q, rser_d;
  logic [WSERIAL_WIDTH-1:0] wser_q, wser_d;
  logic                     err_q, err_d;

  entry_t new_e, head_e, pres_e;
  logic   full, ack, byp, have, mv, fire, issue_rd, push, pop, rsp_ok;

  // Incoming entry, tagged with the serial of its own type.
  always_comb begin
    new_e.we     = req.req_we;
    new_e.addr   = req.req_addr;
    new_e.data   = req.req_data;
    new_e.serial = req.req_we ? MS_W'(wser_q) : MS_W'(rser_q);
  end

  assign head_e = ram_q[rd_ptr_q];
  // Full is taken from the count; equal pointers are ambiguous.
  assign full   = (occ_q == OCC_W'(DEPTH));
  // Gated by reset so nothing is acknowledged while held in reset.
  assign ack    = rst_i & req.req_valid & ~full;

`ifdef DCACHE_MEM_REQ_BYPASS_EN
  // Empty queue: present the incoming request directly to memory.
  assign byp = ack & (occ_q == '0);
`else
  assign byp = 1'b0;
`endif

  assign have     = (occ_q != '0) | byp;
  assign pres_e   = byp ? new_e : head_e;
  // Only reads are throttled; a throttled read head also blocks later writes.
  assign mv       = have & ~(~pres_e.we & (out_q == OUT_W'(MAX_OUTSTANDING)));
  assign fire     = mv & mem.mem_ready;
  assign issue_rd = fire & ~pres_e.we;
  // A bypassed request that fires is consumed without touching the buffer.
  assign push     = ack & ~(byp & fire);
  assign pop      = fire & ~byp;
  // A response with nothing outstanding is flagged and otherwise ignored.
  assign rsp_ok   = mem.mem_rsp_valid & (out_q != '0);

  // Next-state for pointers, occupancy, serial counters and read tracking.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    occ_d    = occ_q + OCC_W'(push) - OCC_W'(pop);
    rser_d   = rser_q + SERIAL_WIDTH'(ack & ~req.req_we);
    wser_d   = wser_q + WSERIAL_WIDTH'(ack & req.req_we);
    out_d    = out_q + OUT_W'(issue_rd) - OUT_W'(rsp_ok);
    err_d    = err_q | (mem.mem_rsp_valid & (out_q == '0));
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      out_q    <= '0;
      rser_q   <= '0;
      wser_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      out_q    <= out_d;
      rser_q   <= rser_d;
      wser_q   <= wser_d;
      err_q    <= err_d;
    end
  end

  // Entry storage; contents are don't-care until written, outputs are masked when empty.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    always_ff @(posedge clk_i) begin
      if (push && (wr_ptr_q == PTR_W'(i))) ram_q[i] <= new_e;
    end
  end

  // Output drive; mem fields read zero when nothing is presented.
  always_comb begin
    req.req_ack     = ack;
    req.req_serial  = rser_q;
    req.req_wserial = wser_q;
    mem.mem_valid   = mv;
    mem.mem_we      = have & pres_e.we;
    mem.mem_addr    = have ? pres_e.addr   : '0;
    mem.mem_data    = have ? pres_e.data   : '0;
    mem.mem_serial  = have ? pres_e.serial : '0;
    occupancy_o     = occ_q;
    outstanding_o   = out_q;
    err_underflow_o = err_q;
  end

endmodule

// File: tb/tb_dcache_mem_req_queue.sv
// Scenario bench for dcache_mem_req_queue (default build, no bypass).
// Accepted requests are pushed to a scoreboard; a monitor pops and compares
// on every memory handshake.

module tb_dcache_mem_req_queue;
  localparam int DEPTH = 4, AW = 32, LW = 128, SW = 4, WSW = 4, MAXO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] occ;
  logic [2:0] outs;
  logic       err;

  dcache_mem_req_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .SERIAL_WIDTH(SW), .WSERIAL_WIDTH(WSW)) rq();
  dcache_mem_bus_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MSERIAL_WIDTH(4)) mb();

  dcache_mem_req_queue #(
    .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LINE_WIDTH(LW),
    .SERIAL_WIDTH(SW), .WSERIAL_WIDTH(WSW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req(rq), .mem(mb),
    .occupancy_o(occ), .outstanding_o(outs), .err_underflow_o(err)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
    logic [3:0]    ser;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  int exp_rs = 0, exp_ws = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [AW-1:0] a);
    rq.req_valid = v;
    rq.req_we    = we;
    rq.req_addr  = a;
    rq.req_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Record the expected memory request for the request being driven now.
  task automatic sb_push();
    exp_t e;
    e.we   = rq.req_we;
    e.addr = rq.req_addr;
    e.data = rq.req_data;
    if (rq.req_we) begin e.ser = exp_ws[3:0]; exp_ws = (exp_ws + 1) % 16; end
    else           begin e.ser = exp_rs[3:0]; exp_rs = (exp_rs + 1) % 16; end
    sb.push_back(e);
  endtask

  // Memory-side monitor: each handshake must match the oldest accepted request.
  always @(negedge clk) begin
    if (rst && mb.mem_valid && mb.mem_ready) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL mon_spurious got addr=%h with empty scoreboard", mb.mem_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (mb.mem_we !== e.we || mb.mem_addr !== e.addr || mb.mem_serial !== e.ser ||
            (e.we && mb.mem_data !== e.data)) begin
          n_fail++;
          $display("FAIL mon_issue got we=%b addr=%h ser=%0d data=%h exp we=%b addr=%h ser=%0d data=%h",
                   mb.mem_we, mb.mem_addr, mb.mem_serial, mb.mem_data, e.we, e.addr, e.ser, e.data);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h1234);
    mb.mem_ready = 1'b1; mb.mem_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (occ !== 3'd0)  begin n_fail++; $display("FAIL rst_occ got=%0d exp=0", occ); end
    n_chk++; if (outs !== 3'd0) begin n_fail++; $display("FAIL rst_outs got=%0d exp=0", outs); end
    n_chk++; if (err !== 1'b0)  begin n_fail++; $display("FAIL rst_err got=%b exp=0", err); end
    n_chk++; if (mb.mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_valid got=%b exp=0", mb.mem_valid); end
    n_chk++; if (rq.req_ack !== 1'b0)   begin n_fail++; $display("FAIL rst_ack got=%b exp=0", rq.req_ack); end
    n_chk++; if (mb.mem_addr !== 32'h0 || mb.mem_serial !== 4'h0 || rq.req_serial !== 4'h0 || rq.req_wserial !== 4'h0) begin
      n_fail++; $display("FAIL rst_fields got addr=%h ms=%0d rs=%0d ws=%0d exp 0", mb.mem_addr, mb.mem_serial, rq.req_serial, rq.req_wserial);
    end
    #1 drive(1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    drive(1'b1, 1'b0, 32'h1000); mb.mem_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (rq.req_ack !== 1'b1 || rq.req_serial !== 4'd0) begin n_fail++; $display("FAIL rd_ack got ack=%b ser=%0d exp 1/0", rq.req_ack, rq.req_serial); end
    n_chk++; if (mb.mem_valid !== 1'b0) begin n_fail++; $display("FAIL rd_latency got mem_valid=%b exp=0", mb.mem_valid); end
    sb_push(); tick();
    drive(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    n_chk++; if (mb.mem_valid !== 1'b1 || mb.mem_addr !== 32'h1000 || mb.mem_serial !== 4'd0 || occ !== 3'd1) begin
      n_fail++; $display("FAIL rd_present got v=%b addr=%h ser=%0d occ=%0d exp 1/1000/0/1", mb.mem_valid, mb.mem_addr, mb.mem_serial, occ);
    end
    tick();
    @(negedge clk);
    n_chk++; if (outs !== 3'd1 || occ !== 3'd0 || mb.mem_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_issued got outs=%0d occ=%0d v=%b exp 1/0/0", outs, occ, mb.mem_valid);
    end
    tick(); mb.mem_rsp_valid = 1'b1; tick(); mb.mem_rsp_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (outs !== 3'd0) begin n_fail++; $display("FAIL rd_rsp got outs=%0d exp=0", outs); end
    tick();
  endtask

  task automatic test_fill_writes();
    mb.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h2000 + 32'(i * 64));
      @(negedge clk);
      n_chk++; if (rq.req_ack !== 1'b1 || rq.req_wserial !== exp_ws[3:0] || rq.req_serial !== exp_rs[3:0]) begin
        n_fail++; $display("FAIL fill_push%0d got ack=%b ws=%0d rs=%0d exp 1/%0d/%0d", i, rq.req_ack, rq.req_wserial, rq.req_serial, exp_ws, exp_rs);
      end
      sb_push(); tick();
    end
    // Full queue refuses even while the head pops this very cycle.
    drive(1'b1, 1'b1, 32'h3000); mb.mem_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (occ !== 3'd4 || rq.req_ack !== 1'b0 || mb.mem_valid !== 1'b1) begin
      n_fail++; $display("FAIL fill_full got occ=%0d ack=%b v=%b exp 4/0/1", occ, rq.req_ack, mb.mem_valid);
    end
    tick();
    drive(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if (occ !== 3'(3 - i) || mb.mem_valid !== 1'b1) begin
        n_fail++; $display("FAIL fill_drain%0d got occ=%0d v=%b exp %0d/1", i, occ, mb.mem_valid, 3 - i);
      end
      tick();
    end
    @(negedge clk);
    n_chk++; if (occ !== 3'd0 || mb.mem_valid !== 1'b0) begin n_fail++; $display("FAIL fill_empty got occ=%0d v=%b exp 0/0", occ, mb.mem_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    mb.mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 32'h4000 + 32'(i * 64));
      @(negedge clk);
      n_chk++; if (rq.req_ack !== 1'b1 || (i > 0 && occ !== 3'd1)) begin
        n_fail++; $display("FAIL b2b%0d got ack=%b occ=%0d exp 1/1", i, rq.req_ack, occ);
      end
      sb_push(); tick();
    end
    drive(1'b0, 1'b0, 32'h0);
    tick();
    @(negedge clk);
    n_chk++; if (occ !== 3'd0) begin n_fail++; $display("FAIL b2b_end got occ=%0d exp=0", occ); end
    tick();
  endtask

  task automatic test_throttle();
    mb.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h5000 + 32'(i * 64));
      @(negedge clk);
      n_chk++; if (rq.req_ack !== 1'b1) begin n_fail++; $display("FAIL thr_push%0d got ack=%b exp=1", i, rq.req_ack); end
      sb_push(); tick();
    end
    drive(1'b1, 1'b1, 32'h6000);
    @(negedge clk);
    n_chk++; if (mb.mem_valid !== 1'b0 || occ !== 3'd1 || outs !== 3'd4) begin
      n_fail++; $display("FAIL thr_block got v=%b occ=%0d outs=%0d exp 0/1/4", mb.mem_valid, occ, outs);
    end
    sb_push(); tick();
    drive(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    n_chk++; if (mb.mem_valid !== 1'b0 || occ !== 3'd2) begin
      n_fail++; $display("FAIL thr_inorder got v=%b occ=%0d exp 0/2", mb.mem_valid, occ);
    end
    tick();
    mb.mem_rsp_valid = 1'b1;
    @(negedge clk);
    n_chk++; if (mb.mem_valid !== 1'b0) begin n_fail++; $display("FAIL thr_rsp_same got v=%b exp=0", mb.mem_valid); end
    tick(); mb.mem_rsp_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (mb.mem_valid !== 1'b1 || mb.mem_addr !== 32'h5100 || outs !== 3'd3) begin
      n_fail++; $display("FAIL thr_release got v=%b addr=%h outs=%0d exp 1/5100/3", mb.mem_valid, mb.mem_addr, outs);
    end
    tick();
    @(negedge clk);
    n_chk++; if (mb.mem_valid !== 1'b1 || mb.mem_we !== 1'b1 || outs !== 3'd4) begin
      n_fail++; $display("FAIL thr_write got v=%b we=%b outs=%0d exp 1/1/4", mb.mem_valid, mb.mem_we, outs);
    end
    tick();
    @(negedge clk);
    n_chk++; if (occ !== 3'd0 || outs !== 3'd4) begin n_fail++; $display("FAIL thr_drained got occ=%0d outs=%0d exp 0/4", occ, outs); end
    tick(); mb.mem_rsp_valid = 1'b1; repeat (4) tick(); mb.mem_rsp_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (outs !== 3'd0 || err !== 1'b0) begin n_fail++; $display("FAIL thr_rsp_all got outs=%0d err=%b exp 0/0", outs, err); end
    tick();
  endtask

  task automatic test_serial_wrap();
    mb.mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(i < 17, 1'b0, 32'h8000 + 32'(i * 64));
      mb.mem_rsp_valid = (i >= 2 && i <= 18);
      @(negedge clk);
      if (i < 17) begin
        n_chk++; if (rq.req_ack !== 1'b1 || rq.req_serial !== exp_rs[3:0]) begin
          n_fail++; $display("FAIL wrap_ser%0d got ack=%b ser=%0d exp 1/%0d", i, rq.req_ack, rq.req_serial, exp_rs);
        end
        sb_push();
      end
      if (i >= 2 && i <= 18) begin
        n_chk++; if (outs !== 3'd1) begin n_fail++; $display("FAIL wrap_outs%0d got=%0d exp=1", i, outs); end
      end
      tick();
    end
    drive(1'b0, 1'b0, 32'h0); mb.mem_rsp_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (outs !== 3'd0 || err !== 1'b0 || occ !== 3'd0) begin
      n_fail++; $display("FAIL wrap_end got outs=%0d err=%b occ=%0d exp 0/0/0", outs, err, occ);
    end
    tick();
  endtask

  task automatic test_rsp_same_cycle();
    mb.mem_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h9000); @(negedge clk); sb_push(); tick();
    drive(1'b1, 1'b0, 32'h9040); @(negedge clk); sb_push(); tick();
    drive(1'b0, 1'b0, 32'h0); mb.mem_rsp_valid = 1'b1;
    @(negedge clk);
    n_chk++; if (mb.mem_valid !== 1'b1 || outs !== 3'd1) begin
      n_fail++; $display("FAIL same_pre got v=%b outs=%0d exp 1/1", mb.mem_valid, outs);
    end
    tick(); mb.mem_rsp_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (outs !== 3'd1) begin n_fail++; $display("FAIL same_cycle got outs=%0d exp=1", outs); end
    tick(); mb.mem_rsp_valid = 1'b1; tick(); mb.mem_rsp_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (outs !== 3'd0 || err !== 1'b0) begin n_fail++; $display("FAIL same_drain got outs=%0d err=%b exp 0/0", outs, err); end
    tick(); mb.mem_rsp_valid = 1'b1; tick(); mb.mem_rsp_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (err !== 1'b1 || outs !== 3'd0) begin n_fail++; $display("FAIL underflow got err=%b outs=%0d exp 1/0", err, outs); end
    repeat (3) tick();
    @(negedge clk);
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky got err=%b exp=1", err); end
    tick();
  endtask

  task automatic test_reset_mid();
    mb.mem_ready = 1'b1;
    drive(1'b1, 1'b0, 32'hA000); @(negedge clk); sb_push(); tick();
    drive(1'b1, 1'b0, 32'hA040); @(negedge clk); sb_push(); tick();
    drive(1'b0, 1'b0, 32'h0);    @(negedge clk); tick();
    mb.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'hB000 + 32'(i * 64)); @(negedge clk); sb_push(); tick();
    end
    drive(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    n_chk++; if (occ !== 3'd3 || outs !== 3'd2) begin n_fail++; $display("FAIL mid_pre got occ=%0d outs=%0d exp 3/2", occ, outs); end
    mb.mem_ready = 1'b1;
    #1 rst = 1'b0;
    #1;
    n_chk++; if (occ !== 3'd0 || outs !== 3'd0 || mb.mem_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL mid_async got occ=%0d outs=%0d v=%b err=%b exp 0/0/0/0", occ, outs, mb.mem_valid, err);
    end
    sb.delete(); exp_rs = 0; exp_ws = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_chk++; if (mb.mem_valid !== 1'b0) begin n_fail++; $display("FAIL mid_hold%0d got v=%b exp=0", i, mb.mem_valid); end
    end
    #1 rst = 1'b1;
    @(negedge clk);
    n_chk++; if (occ !== 3'd0 || outs !== 3'd0 || mb.mem_valid !== 1'b0 || rq.req_serial !== 4'd0) begin
      n_fail++; $display("FAIL mid_release got occ=%0d outs=%0d v=%b rs=%0d exp 0/0/0/0", occ, outs, mb.mem_valid, rq.req_serial);
    end
    tick();
    drive(1'b1, 1'b0, 32'hC000);
    @(negedge clk);
    n_chk++; if (rq.req_ack !== 1'b1 || rq.req_serial !== 4'd0) begin n_fail++; $display("FAIL mid_after got ack=%b ser=%0d exp 1/0", rq.req_ack, rq.req_serial); end
    sb_push(); tick();
    drive(1'b0, 1'b0, 32'h0);
    @(negedge clk); tick();
    @(negedge clk);
    n_chk++; if (outs !== 3'd1 || sb.size() != 0) begin n_fail++; $display("FAIL mid_final got outs=%0d pending=%0d exp 1/0", outs, sb.size()); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fill_writes();
    test_back_to_back();
    test_throttle();
    test_serial_wrap();
    test_rsp_same_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_mem_req_queue.md
Name: dcache_mem_req_queue

Overview:
- Sits between the D-cache memory-request port multiplexer and the external memory port.
- Buffers line-granular read (refill) and write (write-back) requests issued by MSHRs.
- Assigns the read serial and write serial on acceptance, and issues requests in order to memory.
- Throttles reads against an outstanding-read limit, tracked by counting memory read responses.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
ADDR_WIDTH, 32, physical line address width
LINE_WIDTH, 128, cache line data width
SERIAL_WIDTH, 4, read serial width
WSERIAL_WIDTH, 4, write serial width
MAX_OUTSTANDING, 4, max reads issued but not yet answered (1..2^SERIAL_WIDTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
req_valid  in  1  MSHR-side request present
req_we  in  1  1=write-back, 0=refill read
req_addr  in  ADDR_WIDTH  line address
req_data  in  LINE_WIDTH  write data (ignored for reads)
req_ack  out  1  request accepted this cycle
req_serial  out  SERIAL_WIDTH  read serial assigned this cycle (valid with req_ack & !req_we)
req_wserial  out  WSERIAL_WIDTH  write serial assigned this cycle (valid with req_ack & req_we)
mem_valid  out  1  request presented to memory
mem_we  out  1  head entry type
mem_addr  out  ADDR_WIDTH  head address
mem_data  out  LINE_WIDTH  head data
mem_serial  out  max(SERIAL_WIDTH,WSERIAL_WIDTH)  head serial, zero-extended
mem_ready  in  1  memory accepts request this cycle
mem_rsp_valid  in  1  memory returned one read response
occupancy  out  $clog2(DEPTH)+1  valid entries
outstanding  out  $clog2(MAX_OUTSTANDING)+1  issued, unanswered reads
err_underflow  out  1  sticky: response received with outstanding==0

Behaviour:
- Reset (rst=0, async): pointers 0, occupancy 0, outstanding 0, both serial counters 0, err_underflow 0. All outputs 0: mem_valid, mem_we, mem_addr, mem_data, mem_serial, req_ack, req_serial, req_wserial.
- req_ack = req_valid & (occupancy < DEPTH). This is combinational. A full queue never accepts, even if a pop occurs in the same cycle.
- On accept, entry {we, addr, data, serial} is written at the tail and the tail advances modulo DEPTH.
- req_serial/req_wserial are combinationally the current read/write counter values.
- On accept, the matching counter increments, wrapping modulo 2^width. The other counter is unchanged.
- Storage is a registered circular buffer. An entry accepted in cycle N is visible at the head no earlier than N+1 (without bypass).
- mem_valid = (occupancy>0) & !(head.we==0 & outstanding==MAX_OUTSTANDING). Writes are never throttled.
- Strict in-order issue: a throttled read at the head blocks any writes behind it.
- mem_* fields reflect the head entry while mem_valid=1. mem_valid stays asserted and fields stay stable until mem_ready.
- Pop occurs when mem_valid & mem_ready. The head advances modulo DEPTH.
- outstanding_next = outstanding + (pop & head read) - mem_rsp_valid. Issue and response in the same cycle leave it unchanged.
- If mem_rsp_valid arrives with outstanding==0: outstanding stays 0 and err_underflow is set. err_underflow clears only on reset.
- Simultaneous push and pop: occupancy unchanged, both pointers advance.
- Pointer wrap: DEPTH-1 -> 0. Full is detected via occupancy==DEPTH, never by pointer equality alone.
- Reset mid-operation: queued entries are discarded, outstanding is cleared, no memory request is issued during reset.

Optional Feature:
DCACHE_MEM_REQ_BYPASS_EN
- Defined: when occupancy==0 and req_valid, the request is presented on mem_* in the same cycle, with serial = current counter value. mem_valid obeys the read throttle.
  - If mem_ready=1, the request is consumed without being written to the queue: req_ack=1, the counter increments, outstanding counts the read, occupancy stays 0.
  - If mem_ready=0, the request is enqueued normally.
- Undefined: minimum request-to-mem_valid latency is 1 cycle, and mem_* is driven only from the queue head.

Test Plan:
- Reset, then read addr 0x1000 accepted in cycle 0 -> req_serial=0. Without bypass: mem_valid=1, mem_addr=0x1000, mem_serial=0 in cycle 1. With mem_ready=1, outstanding=1 in cycle 2.
- mem_ready=0, push 4 writes -> req_wserial 0,1,2,3, occupancy=4. 5th req_valid gives req_ack=0. Then mem_ready=1 -> writes issue in order, one per cycle, data intact.
- MAX_OUTSTANDING=4, memory never responds, 5 reads -> 4 issued, then mem_valid=0 with occupancy=1. One mem_rsp_valid -> 5th read issues next cycle, outstanding returns to 4.
- 17 reads with SERIAL_WIDTH=4 and responses returned -> serials 0..15 then 0. Pointers wrap with no data corruption.
- Issue one read, and in the same cycle mem_ready=1 with mem_rsp_valid=1 from a prior read -> outstanding unchanged. mem_rsp_valid at outstanding=0 -> err_underflow=1 and stays set.
- Assert rst low with 3 entries queued and outstanding=2 -> occupancy=0, outstanding=0, mem_valid=0 immediately and after release.
